fft8_engine: RTL and testbench

FFT8_ENGINE -- requirements
Module: fft8_engine

---
 rtl/fft8_engine.sv | 259 +++++++++++++++++++++++++
 tb/tb_fft8_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fft8_engine
//
// Purpose:
//   8-point radix-2 decimation-in-time FFT, scaled by 1/8 (each butterfly
//   output is halved). Samples are captured in bit-reversed order into a
//   small complex register RAM, transformed in place at one butterfly per
//   clock (3 stages x 4 butterflies), then streamed out as bins 0..7.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle request; honoured only when idle
//   x0..x7     16-bit offset-binary samples, x0 is sample n=0
//   busy       high while transforming or streaming bins
//   out_valid  a bin is present on out_re/out_im/out_index
//   out_index  bin number k of the current output
//   out_re     signed real part of bin k (zero when out_valid is low)
//   out_im     signed imaginary part of bin k (zero when out_valid is low)
//   done       one-cycle pulse alongside the k=7 bin
//
// Timing (start sampled at edge T):
//   T+1..T+12  butterflies; T+13..T+20 bins k=0..7; idle again after T+20.
// ---------------------------------------------------------------------------
module fft8_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x0,
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    input  logic [15:0] x3,
    input  logic [15:0] x4,
    input  logic [15:0] x5,
    input  logic [15:0] x6,
    input  logic [15:0] x7,
    output logic        busy,
    output logic        out_valid,
    output logic [2:0]  out_index,
    output logic [15:0] out_re,
    output logic [15:0] out_im,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BFLY = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;        // butterfly number in BFLY, bin number in OUT
    logic        out_valid_q, out_valid_d;
    logic        done_q, done_d;
    logic [2:0]  out_index_q, out_index_d;
    logic [15:0] out_re_q, out_re_d;
    logic [15:0] out_im_q, out_im_d;

    // Complex working store, updated in place by the butterflies
    logic signed [15:0] mem_re_q [8];
    logic signed [15:0] mem_im_q [8];

    // Input samples converted from offset binary to two's complement
    logic [15:0]        x_raw    [8];
    logic signed [15:0] sample_s [8];

    assign x_raw = '{x0, x1, x2, x3, x4, x5, x6, x7};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_conv
            assign sample_s[gi] = {~x_raw[gi][15], x_raw[gi][14:0]};
        end
    endgenerate

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    logic capture_en;
    logic bfly_en;

    assign capture_en = rst_n && (state_q == IDLE) && start;
    assign bfly_en    = rst_n && (state_q == BFLY);

    // -----------------------------------------------------------------------
    // Butterfly addressing: step_q[3:2] is the stage, step_q[1:0] the
    // butterfly within it. Spans are 1, 2, 4; twiddle exponent is the
    // position inside the group scaled to the W8 grid.
    // -----------------------------------------------------------------------
    logic [2:0] top_idx;
    logic [2:0] bot_idx;
    logic [1:0] tw_sel;

    always_comb begin
        top_idx = 3'd0;
        bot_idx = 3'd1;
        tw_sel  = 2'd0;
        case (step_q[3:2])
            2'd0: begin
                top_idx = {step_q[1:0], 1'b0};
                bot_idx = top_idx | 3'd1;
                tw_sel  = 2'd0;
            end
            2'd1: begin
                top_idx = {step_q[1], 1'b0, step_q[0]};
                bot_idx = top_idx | 3'd2;
                tw_sel  = {step_q[0], 1'b0};
            end
            default: begin
                top_idx = {1'b0, step_q[1:0]};
                bot_idx = top_idx | 3'd4;
                tw_sel  = step_q[1:0];
            end
        endcase
    end

    // Twiddle ROM, Q1.14
    logic signed [15:0] w_re;
    logic signed [15:0] w_im;

    always_comb begin
        w_re = 16'sd16384;
        w_im = 16'sd0;
        case (tw_sel)
            2'd0: begin w_re =  16'sd16384; w_im =  16'sd0;     end
            2'd1: begin w_re =  16'sd11585; w_im = -16'sd11585; end
            2'd2: begin w_re =  16'sd0;     w_im = -16'sd16384; end
            default: begin w_re = -16'sd11585; w_im = -16'sd11585; end
        endcase
    end

    // -----------------------------------------------------------------------
    // Butterfly datapath
    // -----------------------------------------------------------------------
    logic signed [15:0] a_re, a_im, b_re, b_im;
    logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [32:0] s_re, s_im;
    logic signed [15:0] t_re, t_im;
    logic signed [16:0] sum_re, sum_im, dif_re, dif_im;
    logic signed [15:0] top_re_new, top_im_new, bot_re_new, bot_im_new;

    assign a_re = mem_re_q[top_idx];
    assign a_im = mem_im_q[top_idx];
    assign b_re = mem_re_q[bot_idx];
    assign b_im = mem_im_q[bot_idx];

    assign p_rr = 32'(w_re) * 32'(b_re);
    assign p_ii = 32'(w_im) * 32'(b_im);
    assign p_ri = 32'(w_re) * 32'(b_im);
    assign p_ir = 32'(w_im) * 32'(b_re);

    assign s_re = 33'(p_rr) - 33'(p_ii);
    assign s_im = 33'(p_ri) + 33'(p_ir);

    // Product rescaled from Q1.14 and truncated back to 16 bits
    assign t_re = 16'(s_re >>> 14);
    assign t_im = 16'(s_im >>> 14);

    assign sum_re = 17'(a_re) + 17'(t_re);
    assign sum_im = 17'(a_im) + 17'(t_im);
    assign dif_re = 17'(a_re) - 17'(t_re);
    assign dif_im = 17'(a_im) - 17'(t_im);

    // Halving every stage gives the overall 1/8 scale and keeps 16 bits
    assign top_re_new = 16'(sum_re >>> 1);
    assign top_im_new = 16'(sum_im >>> 1);
    assign bot_re_new = 16'(dif_re >>> 1);
    assign bot_im_new = 16'(dif_im >>> 1);

    // Working store: no reset, every capture overwrites all eight entries
    always_ff @(posedge clk) begin
        if (capture_en) begin
            for (int i = 0; i < 8; i++) begin
                mem_re_q[bitrev3(3'(i))] <= sample_s[i];
                mem_im_q[bitrev3(3'(i))] <= 16'sd0;
            end
        end else if (bfly_en) begin
            mem_re_q[top_idx] <= top_re_new;
            mem_im_q[top_idx] <= top_im_new;
            mem_re_q[bot_idx] <= bot_re_new;
            mem_im_q[bot_idx] <= bot_im_new;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        out_index_d = 3'd0;
        out_re_d    = 16'd0;
        out_im_d    = 16'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BFLY;
                    step_d  = 4'd0;
                end
            end
            BFLY: begin
                if (step_q == 4'd11) begin
                    state_d = OUT;
                    step_d  = 4'd0;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            OUT: begin
                out_valid_d = 1'b1;
                out_index_d = step_q[2:0];
                out_re_d    = mem_re_q[step_q[2:0]];
                out_im_d    = mem_im_q[step_q[2:0]];
                if (step_q[2:0] == 3'd7) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    step_d  = 4'd0;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= 4'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            out_index_q <= 3'd0;
            out_re_q    <= 16'd0;
            out_im_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            out_index_q <= out_index_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign out_index = out_index_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule

// File: tb/tb_fft8_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fft8_engine
//
// Self-checking bench for fft8_engine. Directed vectors (impulse, DC,
// alternating), control scenarios (ignored starts, back-to-back, reset
// mid-burst) and random vectors checked against an integer FFT model.
// ---------------------------------------------------------------------------
module tb_fft8_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] xv [8];
    logic        busy, out_valid, done;
    logic [2:0]  out_index;
    logic [15:0] out_re, out_im;

    always #31.25 clk = ~clk;

    fft8_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x0        (xv[0]),
        .x1        (xv[1]),
        .x2        (xv[2]),
        .x3        (xv[3]),
        .x4        (xv[4]),
        .x5        (xv[5]),
        .x6        (xv[6]),
        .x7        (xv[7]),
        .busy      (busy),
        .out_valid (out_valid),
        .out_index (out_index),
        .out_re    (out_re),
        .out_im    (out_im),
        .done      (done)
    );

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Results of the most recent transaction
    logic [15:0] cap [8];
    int got_re [8];
    int got_im [8];
    int exp_re [8];
    int exp_im [8];
    int valid_cnt, first_c, last_c, done_c, done_cnt, idx_bad, zero_bad;
    logic busy_mid, busy_end, post_rst_ok;

    int w_re_tab [4] = '{16384, 11585, 0, -11585};
    int w_im_tab [4] = '{0, -11585, -16384, -11585};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bitrev3(int n);
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    endfunction

    function automatic int wrap16(int v);
        return ((v + 32768) & 65535) - 32768;
    endfunction

    // Scaled iterative DIT FFT on cap[] using plain integer arithmetic
    task automatic compute_model();
        int r [8];
        int im [8];
        int top, bot, m, tr, ti, ar, ai;
        for (int n = 0; n < 8; n++) begin
            r[bitrev3(n)]  = int'(cap[n]) - 32768;
            im[bitrev3(n)] = 0;
        end
        for (int h = 1; h < 8; h = h * 2) begin
            for (int g = 0; g < 8; g = g + 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    top = g + j;
                    bot = top + h;
                    m   = j * (4 / h);
                    tr  = wrap16((w_re_tab[m] * r[bot] - w_im_tab[m] * im[bot]) >>> 14);
                    ti  = wrap16((w_re_tab[m] * im[bot] + w_im_tab[m] * r[bot]) >>> 14);
                    ar  = r[top];
                    ai  = im[top];
                    r[top]  = (ar + tr) >>> 1;
                    im[top] = (ai + ti) >>> 1;
                    r[bot]  = (ar - tr) >>> 1;
                    im[bot] = (ai - ti) >>> 1;
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            exp_re[k] = r[k];
            exp_im[k] = im[k];
        end
    endtask

    // Pulse start, then watch up to max_c cycles. Optional extra start
    // pulses before edges sa/sb and a one-cycle reset before edge rst_at.
    // Inputs are scrambled after capture to show they are not re-read.
    task automatic run_xfer(input int max_c, input int sa, input int sb, input int rst_at);
        for (int k = 0; k < 8; k++) cap[k] = xv[k];
        valid_cnt = 0; first_c = -1; last_c = -1; done_c = -1; done_cnt = 0;
        idx_bad = 0; zero_bad = 0; busy_mid = 1'b0; post_rst_ok = 1'b0;
        for (int k = 0; k < 8; k++) begin got_re[k] = 0; got_im[k] = 0; end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            start = (c == sa) || (c == sb);
            rst_n = (c != rst_at);
            for (int k = 0; k < 8; k++) xv[k] = 16'($urandom_range(0, 65535));
            tick();
            if (out_valid) begin
                if (valid_cnt < 8) begin
                    got_re[valid_cnt] = int'($signed(out_re));
                    got_im[valid_cnt] = int'($signed(out_im));
                    if (int'(out_index) != valid_cnt) idx_bad++;
                end
                valid_cnt++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end else if ((out_re != 16'd0) || (out_im != 16'd0) || (out_index != 3'd0)) begin
                zero_bad++;
            end
            if (done) begin
                done_cnt++;
                done_c = c;
            end
            if (c == 12) busy_mid = busy;
            if (c == rst_at)
                post_rst_ok = !out_valid && !busy && !done && (out_re == 16'd0)
                              && (out_im == 16'd0) && (out_index == 3'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        busy_end = busy;
    endtask

    task automatic set_all(input logic [15:0] even_v, input logic [15:0] odd_v);
        for (int k = 0; k < 8; k++) xv[k] = (k % 2 == 0) ? even_v : odd_v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;                       // reset must win over start
        for (int k = 0; k < 8; k++) xv[k] = 16'($urandom_range(0, 65535));
        repeat (3) tick();
        check_cnt++;
        if ({busy, out_valid, done, out_index, out_re, out_im} !== 36'd0)
            $display("FAIL reset_outputs: got busy=%0b valid=%0b done=%0b idx=%0d re=%0h im=%0h, want all 0",
                     busy, out_valid, done, out_index, out_re, out_im);
        else pass_cnt++;
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL reset_no_capture: got busy=%0b valid=%0b, want 0 0", busy, out_valid);
        else pass_cnt++;
        $display("test_reset: done");
    endtask

    task automatic test_impulse();
        set_all(16'h8000, 16'h8000);
        xv[0] = 16'hC000;
        run_xfer(24, -1, -1, -1);
        check_cnt++;
        if (first_c != 13 || last_c != 20 || valid_cnt != 8)
            $display("FAIL impulse_latency: got first=%0d last=%0d count=%0d, want 13 20 8",
                     first_c, last_c, valid_cnt);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            check_cnt++;
            if (got_re[k] != 2048 || got_im[k] != 0)
                $display("FAIL impulse_bin%0d: got (%0d,%0d), want (2048,0)", k, got_re[k], got_im[k]);
            else pass_cnt++;
        end
        check_cnt++;
        if (busy_mid !== 1'b1 || busy_end !== 1'b0)
            $display("FAIL impulse_busy: got mid=%0b end=%0b, want 1 0", busy_mid, busy_end);
        else pass_cnt++;
        $display("test_impulse: first=%0d last=%0d", first_c, last_c);
    endtask

    task automatic test_dc();
        set_all(16'hC000, 16'hC000);
        run_xfer(24, -1, -1, -1);
        for (int k = 0; k < 8; k++) begin
            check_cnt++;
            if (got_re[k] != ((k == 0) ? 16384 : 0) || got_im[k] != 0)
                $display("FAIL dc_bin%0d: got (%0d,%0d), want (%0d,0)", k, got_re[k], got_im[k],
                         (k == 0) ? 16384 : 0);
            else pass_cnt++;
        end
        check_cnt++;
        if (done_cnt != 1 || done_c != 20 || idx_bad != 0 || zero_bad != 0)
            $display("FAIL dc_done: got done_cnt=%0d done_c=%0d idx_bad=%0d zero_bad=%0d, want 1 20 0 0",
                     done_cnt, done_c, idx_bad, zero_bad);
        else pass_cnt++;
        $display("test_dc: done at cycle %0d", done_c);
    endtask

    task automatic test_alternating();
        set_all(16'hC000, 16'h4000);
        run_xfer(24, -1, -1, -1);
        for (int k = 0; k < 8; k++) begin
            check_cnt++;
            if (got_re[k] != ((k == 4) ? 16384 : 0) || got_im[k] != 0)
                $display("FAIL alt_bin%0d: got (%0d,%0d), want (%0d,0)", k, got_re[k], got_im[k],
                         (k == 4) ? 16384 : 0);
            else pass_cnt++;
        end
        $display("test_alternating: X4=(%0d,%0d)", got_re[4], got_im[4]);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) xv[k] = 16'($urandom_range(0, 65535));
        run_xfer(20, 5, 15, -1);           // extra starts in BFLY and OUT
        compute_model();
        check_cnt++;
        if (valid_cnt != 8 || done_cnt != 1 || idx_bad != 0)
            $display("FAIL ignore_start: got valid=%0d done=%0d idx_bad=%0d, want 8 1 0",
                     valid_cnt, done_cnt, idx_bad);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            check_cnt++;
            if (got_re[k] != exp_re[k] || got_im[k] != exp_im[k])
                $display("FAIL ignore_start_bin%0d: got (%0d,%0d), want (%0d,%0d)", k,
                         got_re[k], got_im[k], exp_re[k], exp_im[k]);
            else pass_cnt++;
        end
        // Next start right after the done cycle
        for (int k = 0; k < 8; k++) xv[k] = 16'($urandom_range(0, 65535));
        run_xfer(24, -1, -1, -1);
        compute_model();
        check_cnt++;
        if (first_c != 13 || valid_cnt != 8)
            $display("FAIL back_to_back_accept: got first=%0d valid=%0d, want 13 8", first_c, valid_cnt);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            check_cnt++;
            if (got_re[k] != exp_re[k] || got_im[k] != exp_im[k])
                $display("FAIL back_to_back_bin%0d: got (%0d,%0d), want (%0d,%0d)", k,
                         got_re[k], got_im[k], exp_re[k], exp_im[k]);
            else pass_cnt++;
        end
        $display("test_back_to_back: second first=%0d", first_c);
    endtask

    task automatic test_reset_mid_out();
        for (int k = 0; k < 8; k++) xv[k] = 16'($urandom_range(0, 65535));
        run_xfer(24, -1, -1, 17);          // edge 17 would have loaded k=4
        check_cnt++;
        if (valid_cnt != 4 || done_cnt != 0 || !post_rst_ok || busy_end !== 1'b0)
            $display("FAIL reset_mid_out: got valid=%0d done=%0d clean=%0b busy=%0b, want 4 0 1 0",
                     valid_cnt, done_cnt, post_rst_ok, busy_end);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) xv[k] = 16'($urandom_range(0, 65535));
        run_xfer(24, -1, -1, -1);
        compute_model();
        for (int k = 0; k < 8; k++) begin
            check_cnt++;
            if (got_re[k] != exp_re[k] || got_im[k] != exp_im[k])
                $display("FAIL after_reset_bin%0d: got (%0d,%0d), want (%0d,%0d)", k,
                         got_re[k], got_im[k], exp_re[k], exp_im[k]);
            else pass_cnt++;
        end
        $display("test_reset_mid_out: bins before reset=%0d", 4);
    endtask

    task automatic test_random();
        logic [15:0] corner [4];
        int bad;
        corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        for (int v = 0; v < 1000; v++) begin
            for (int k = 0; k < 8; k++) begin
                if (v % 8 == 7) xv[k] = corner[$urandom_range(0, 3)];
                else            xv[k] = 16'($urandom_range(0, 65535));
            end
            run_xfer(24, -1, -1, -1);
            compute_model();
            bad = 0;
            for (int k = 0; k < 8; k++) begin
                check_cnt++;
                if (got_re[k] != exp_re[k] || got_im[k] != exp_im[k]) begin
                    $display("FAIL random%0d_bin%0d: got (%0d,%0d), want (%0d,%0d)", v, k,
                             got_re[k], got_im[k], exp_re[k], exp_im[k]);
                    bad++;
                end else pass_cnt++;
            end
            check_cnt++;
            if (valid_cnt != 8 || idx_bad != 0 || zero_bad != 0 || first_c != 13) begin
                $display("FAIL random%0d_seq: got valid=%0d idx_bad=%0d zero_bad=%0d first=%0d, want 8 0 0 13",
                         v, valid_cnt, idx_bad, zero_bad, first_c);
                bad++;
            end else pass_cnt++;
            $display("random vector %0d: %0s", v, (bad == 0) ? "ok" : "bad");
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) xv[k] = 16'h8000;
        test_reset();
        test_impulse();
        test_dc();
        test_alternating();
        test_back_to_back();
        test_reset_mid_out();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
